// File: rtl/cbd_down_counter.sv
// Cascadable down counter with borrow-in/borrow-out, synchronous preset/clear/load,
// optional auto-reload from R on underflow, and a registered terminal-count pulse.
module cbd_down_counter #(
  parameter int unsigned WIDTH  = 4,
  parameter bit          RELOAD = 1'b0
) (
  input  logic             CLK,
  input  logic             CD,
  input  logic             PS,
  input  logic             CS,
  input  logic             LD,
  input  logic             WR,
  input  logic [WIDTH-1:0] D,
  input  logic             BI,
  input  logic             EN,
  output logic [WIDTH-1:0] Q,
  output logic             BO,
  output logic             TC
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_next;
  logic             dec;
  logic             uf;
  logic             ctl;

  assign dec = BI & EN;
  assign uf  = dec & (Q == '0);
  assign ctl = PS | CS | LD;

  // Borrow-out reflects the pre-edge state; synchronous controls never mask it.
  assign BO = uf;

  always_comb begin
    q_next = Q;
    if (PS)                q_next = '1;
    else if (CS)           q_next = '0;
    else if (LD)           q_next = D;
    else if (uf && RELOAD) q_next = r_q;
    else if (dec)          q_next = Q - ONE;
  end

  always_ff @(posedge CLK or posedge CD) begin
    if (CD) begin
      Q   <= '0;
      r_q <= '0;
      TC  <= 1'b0;
    end else begin
      Q  <= q_next;
      TC <= uf & ~ctl;
      // Reload register is written independently of the Q priority chain.
      if (WR) r_q <= D;
    end
  end

endmodule

// File: tb/tb_cbd_down_counter.sv
// Self-checking bench: a wrapping 4-bit slice, an auto-reload 4-bit slice and a
// two-slice 8-bit cascade, all checked every cycle against an arithmetic model.
module tb_cbd_down_counter;

  logic       clk = 1'b0;
  logic       cd, ps, cs, ld, wr, bi, en;
  logic [3:0] d;
  logic [7:0] d8;

  logic [3:0] qa, qb, q_lo, q_hi;
  logic       bo_a, tc_a, bo_b, tc_b, bo_lo, tc_lo, bo_hi, tc_hi;

  int n_cmp = 0;
  int n_err = 0;

  // model state: plain integers following the behavioural rules
  int m_a, m_atc, m_b, m_r, m_btc, m_c, m_ctl, m_cth;
  int m_dec, m_ctrl;

  always #5 clk = ~clk;

  cbd_down_counter #(.WIDTH(4), .RELOAD(1'b0)) dut_a (
    .CLK(clk), .CD(cd), .PS(ps), .CS(cs), .LD(ld), .WR(wr), .D(d),
    .BI(bi), .EN(en), .Q(qa), .BO(bo_a), .TC(tc_a));

  cbd_down_counter #(.WIDTH(4), .RELOAD(1'b1)) dut_b (
    .CLK(clk), .CD(cd), .PS(ps), .CS(cs), .LD(ld), .WR(wr), .D(d),
    .BI(bi), .EN(en), .Q(qb), .BO(bo_b), .TC(tc_b));

  cbd_down_counter #(.WIDTH(4), .RELOAD(1'b0)) dut_lo (
    .CLK(clk), .CD(cd), .PS(ps), .CS(cs), .LD(ld), .WR(wr), .D(d8[3:0]),
    .BI(bi), .EN(en), .Q(q_lo), .BO(bo_lo), .TC(tc_lo));

  cbd_down_counter #(.WIDTH(4), .RELOAD(1'b0)) dut_hi (
    .CLK(clk), .CD(cd), .PS(ps), .CS(cs), .LD(ld), .WR(wr), .D(d8[7:4]),
    .BI(bo_lo), .EN(en), .Q(q_hi), .BO(bo_hi), .TC(tc_hi));

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: the cascade is modelled as one 8-bit value.
  always @(posedge clk or posedge cd) begin
    if (cd) begin
      m_a = 0; m_atc = 0; m_b = 0; m_r = 0; m_btc = 0;
      m_c = 0; m_ctl = 0; m_cth = 0;
    end else begin
      m_dec  = (bi && en) ? 1 : 0;
      m_ctrl = (ps || cs || ld) ? 1 : 0;
      m_atc  = (m_dec && m_a == 0 && !m_ctrl) ? 1 : 0;
      m_btc  = (m_dec && m_b == 0 && !m_ctrl) ? 1 : 0;
      m_ctl  = (m_dec && (m_c % 16) == 0 && !m_ctrl) ? 1 : 0;
      m_cth  = (m_dec && m_c == 0 && !m_ctrl) ? 1 : 0;
      if (ps) begin
        m_a = 15; m_b = 15; m_c = 255;
      end else if (cs) begin
        m_a = 0; m_b = 0; m_c = 0;
      end else if (ld) begin
        m_a = int'(d); m_b = int'(d); m_c = int'(d8);
      end else if (m_dec) begin
        m_a = (m_a + 15) % 16;
        m_b = (m_b == 0) ? m_r : m_b - 1;
        m_c = (m_c + 255) % 256;
      end
      if (wr) m_r = int'(d);
    end
  end

  always @(negedge clk) begin
    chk("a_q",   int'(qa),   m_a);
    chk("a_tc",  int'(tc_a), m_atc);
    chk("a_bo",  int'(bo_a), (bi && en && m_a == 0) ? 1 : 0);
    chk("b_q",   int'(qb),   m_b);
    chk("b_tc",  int'(tc_b), m_btc);
    chk("b_bo",  int'(bo_b), (bi && en && m_b == 0) ? 1 : 0);
    chk("c_q",   int'({q_hi, q_lo}), m_c);
    chk("c_tclo", int'(tc_lo), m_ctl);
    chk("c_tchi", int'(tc_hi), m_cth);
    chk("c_bolo", int'(bo_lo), (bi && en && (m_c % 16) == 0) ? 1 : 0);
    chk("c_bohi", int'(bo_hi), (bi && en && m_c == 0) ? 1 : 0);
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_ctl();
    ps = 0; cs = 0; ld = 0; wr = 0;
  endtask

  initial begin
    int e;
    cd = 1; idle_ctl(); d = 0; d8 = 0; bi = 1; en = 1;

    // reset and wrap
    cyc();
    chk("rst_q", int'(qa), 0);
    chk("rst_tc", int'(tc_a), 0);
    chk("rst_bo", int'(bo_a), 1);
    cd = 0;
    for (int i = 1; i <= 17; i++) begin
      cyc();
      e = ((16 - i) % 16 + 16) % 16;
      chk("wrap_q", int'(qa), e);
      chk("wrap_tc", int'(tc_a), (e == 15) ? 1 : 0);
      chk("wrap_bo", int'(bo_a), (e == 0) ? 1 : 0);
    end

    // auto-reload with R=5, then R=0
    wr = 1; d = 4'd5; cs = 1;
    cyc();
    chk("rl_q0", int'(qb), 0);
    idle_ctl();
    for (int i = 1; i <= 14; i++) begin
      cyc();
      chk("rl_q", int'(qb), 5 - ((i - 1) % 6));
      chk("rl_tc", int'(tc_b), ((i - 1) % 6 == 0) ? 1 : 0);
    end
    wr = 1; d = 4'd0; cs = 1;
    cyc();
    chk("r0_tc0", int'(tc_b), 0);
    idle_ctl();
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("r0_q", int'(qb), 0);
      chk("r0_tc", int'(tc_b), 1);
      chk("r0_bo", int'(bo_b), 1);
    end

    // priority PS > CS > LD > count
    cs = 1;
    cyc();
    ps = 1; cs = 1; ld = 1; d = 4'd3; bi = 1; en = 1;
    #1;
    chk("pri_bo", int'(bo_a), 1);
    cyc();
    chk("pri_ps", int'(qa), 15);
    chk("pri_tc", int'(tc_a), 0);
    ps = 0;
    cyc();
    chk("pri_cs", int'(qa), 0);
    cs = 0;
    cyc();
    chk("pri_ld", int'(qa), 3);
    ld = 0;

    // cascade load 0x10 and count through wrap
    ld = 1; d8 = 8'h10;
    cyc();
    chk("cas_ld", int'({q_hi, q_lo}), 8'h10);
    ld = 0;
    cyc();
    chk("cas_0f", int'({q_hi, q_lo}), 8'h0F);
    cyc();
    chk("cas_0e", int'({q_hi, q_lo}), 8'h0E);
    for (int k = 1; k <= 14; k++) begin
      cyc();
      chk("cas_cnt", int'({q_hi, q_lo}), 14 - k);
      chk("cas_bohi", int'(bo_hi), (k == 14) ? 1 : 0);
    end
    cyc();
    chk("cas_wrap", int'({q_hi, q_lo}), 8'hFF);
    chk("cas_tchi", int'(tc_hi), 1);

    // async reset mid-cycle
    ld = 1; d = 4'd9;
    cyc();
    ld = 0; wr = 1; d = 4'd7; en = 0;
    cyc();
    wr = 0;
    chk("ar_q9", int'(qa), 9);
    #2 cd = 1;
    #1;
    chk("ar_qa", int'(qa), 0);
    chk("ar_qb", int'(qb), 0);
    chk("ar_tca", int'(tc_a), 0);
    chk("ar_tcb", int'(tc_b), 0);
    cd = 0; en = 1; bi = 1;
    cyc();
    chk("ar_cnta", int'(qa), 15);
    chk("ar_cntb", int'(qb), 0);

    // enable gating at Q=0
    cs = 1;
    cyc();
    cs = 0; bi = 0; en = 1;
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin bi = 1; en = 0; end
      cyc();
      chk("gate_q", int'(qa), 0);
      chk("gate_bo", int'(bo_a), 0);
      chk("gate_tc", int'(tc_a), 0);
    end

    // randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      cyc();
      ps = ($urandom_range(0, 39) == 0);
      cs = ($urandom_range(0, 29) == 0);
      ld = ($urandom_range(0, 19) == 0);
      wr = ($urandom_range(0, 9) == 0);
      d  = 4'($urandom_range(0, 15));
      d8 = 8'($urandom_range(0, 255));
      bi = ($urandom_range(0, 7) != 0);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 199) == 0) begin
        cd = 1;
        #2 cd = 0;
      end
    end

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
